// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths, control-field offsets and state encoding for pipeline stage registers.
package pipe_pkg;

  localparam int PIPE_DEST_W = 5;
  localparam int PIPE_CTRL_W = 5;
  localparam int PIPE_DATA_W = 32;

  // Packed control field layout: memwrite[1:0], memread[1:0], memtoreg
  localparam int CTRL_MEMWRITE_LSB = 0;
  localparam int CTRL_MEMREAD_LSB  = 2;
  localparam int CTRL_MEMTOREG_BIT = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Second-entry holding register for a pipeline stage: one entry plus its valid bit.
module pipe_skid_buf #(
  parameter int DEST_W = 5,
  parameter int CTRL_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [DEST_W-1:0] dest,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      dest  <= '0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dest  <= in_dest;
      ctrl  <= in_ctrl;
      data  <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and bubble control gating.
// Define PIPE_STAGE_SKID_EN for the two-entry skid variant with a registered in_ready.
//
// state | meaning
// EMPTY | nothing held, out_valid low
// ONE   | main register valid, skid empty
// TWO   | main and skid both valid, in_ready low (skid build only)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DEST_W = PIPE_DEST_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DEST_W-1:0] out_dest,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  pipe_state_t       state_q, state_d;
  logic              xfer_in, xfer_out;
  logic              main_load;
  logic [DEST_W-1:0] main_dest, nxt_dest;
  logic [CTRL_W-1:0] main_ctrl, nxt_ctrl;
  logic [DATA_W-1:0] main_data, nxt_data;

  assign out_valid = (state_q != EMPTY);
  assign xfer_in   = in_valid && in_ready;
  assign xfer_out  = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              in_ready_q;
  logic              main_from_skid;
  logic              skid_load, skid_clear;
  logic              skid_valid;
  logic [DEST_W-1:0] skid_dest;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  pipe_skid_buf #(
    .DEST_W(DEST_W),
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .clear  (skid_clear),
    .in_dest(in_dest),
    .in_ctrl(in_ctrl),
    .in_data(in_data),
    .valid  (skid_valid),
    .dest   (skid_dest),
    .ctrl   (skid_ctrl),
    .data   (skid_data)
  );

  assign in_ready = in_ready_q;
  assign nxt_dest = main_from_skid ? skid_dest : in_dest;
  assign nxt_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign nxt_data = main_from_skid ? skid_data : in_data;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (xfer_in && xfer_out) begin
            main_load = 1'b1;
          end else if (xfer_in) begin
            skid_load = 1'b1;
            state_d   = TWO;
          end else if (xfer_out) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // Skid always drains into main before anything new is accepted
          if (xfer_out && skid_valid) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_ready_q <= 1'b1;
    else      in_ready_q <= (state_d != TWO);
  end
`else
  assign in_ready = out_ready || !out_valid;
  assign nxt_dest = in_dest;
  assign nxt_ctrl = in_ctrl;
  assign nxt_data = in_data;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else if (xfer_in) begin
      main_load = 1'b1;
      state_d   = ONE;
    end else if (xfer_out) begin
      state_d = EMPTY;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      main_dest <= '0;
      main_ctrl <= '0;
      main_data <= '0;
    end else begin
      state_q <= state_d;
      if (main_load) begin
        main_dest <= nxt_dest;
        main_ctrl <= nxt_ctrl;
        main_data <= nxt_data;
      end
    end
  end

  assign out_dest = main_dest;
  assign out_data = main_data;
  // A bubble must never present memwrite/memread/memtoreg downstream
  assign out_ctrl = out_valid ? main_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed test-plan checks plus randomized traffic against a queue model.
module tb_pipe_stage_reg;

  localparam int DEST_W = 5;
  localparam int CTRL_W = 5;
  localparam int DATA_W = 32;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DEST_W-1:0] in_dest = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DEST_W-1:0] out_dest;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  int vectors = 0;
  int miscompares = 0;
  entry_t mq[$];

  pipe_stage_reg #(.DEST_W(DEST_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dest(out_dest), .out_ctrl(out_ctrl), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: a FIFO of capacity CAP; outputs are its head, in_ready is "room for one more"
  always @(negedge clk) begin
    logic exp_ready, xin, xout;
    entry_t e;
    if (!rst) begin
      mq.delete();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
    end else begin
`ifdef PIPE_STAGE_SKID_EN
      exp_ready = (mq.size() < CAP);
`else
      exp_ready = out_ready || (mq.size() == 0);
`endif
      chk("in_ready", 64'(in_ready), 64'(exp_ready));
      chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("out_dest", 64'(out_dest), 64'(mq[0].dest));
        chk("out_ctrl", 64'(out_ctrl), 64'(mq[0].ctrl));
        chk("out_data", 64'(out_data), 64'(mq[0].data));
      end else begin
        chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
      end
      if (flush) begin
        mq.delete();
      end else begin
        xin  = in_valid && exp_ready;
        xout = (mq.size() > 0) && out_ready;
        if (xout) void'(mq.pop_front());
        if (xin) begin
          e.dest = in_dest;
          e.ctrl = in_ctrl;
          e.data = in_data;
          mq.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [DEST_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_dest   = d;
    in_ctrl   = c;
    in_data   = {27'h0, d} ^ 32'hA5A5_0000;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    // Reset held with a live, all-ones-control input: nothing may be captured
    drive(1'b1, 5'd4, 5'h1F, 1'b1, 1'b0);
    tick(); tick(); tick();
    chk("hold_rst_out_valid", 64'(out_valid), 64'd0);
    chk("hold_rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("hold_rst_in_ready", 64'(in_ready), 64'd1);
    chk("hold_rst_out_dest", 64'(out_dest), 64'd0);
    chk("hold_rst_out_data", 64'(out_data), 64'd0);

    // Streaming 1,2,3 with no bubbles
    rst = 1'b1;
    drive(1'b1, 5'd1, 5'h03, 1'b1, 1'b0);
    tick();
    chk("stream1_valid", 64'(out_valid), 64'd1);
    chk("stream1_dest", 64'(out_dest), 64'd1);
    chk("stream1_ctrl", 64'(out_ctrl), 64'h03);
    drive(1'b1, 5'd2, 5'h04, 1'b1, 1'b0);
    tick();
    chk("stream2_dest", 64'(out_dest), 64'd2);
    chk("stream2_data", 64'(out_data), 64'hA5A5_0002);
    drive(1'b1, 5'd3, 5'h10, 1'b1, 1'b0);
    tick();
    chk("stream3_dest", 64'(out_dest), 64'd3);
    chk("stream3_valid", 64'(out_valid), 64'd1);
    drive(1'b0, 5'd0, 5'h1F, 1'b1, 1'b0);
    tick();
    chk("stream_drain_valid", 64'(out_valid), 64'd0);
    chk("stream_drain_ctrl", 64'(out_ctrl), 64'd0);

`ifdef PIPE_STAGE_SKID_EN
    // Stall with skid: 7 presented, 8 absorbed after out_ready drops
    drive(1'b1, 5'd7, 5'h01, 1'b1, 1'b0);
    tick();
    chk("stall_7_dest", 64'(out_dest), 64'd7);
    drive(1'b1, 5'd8, 5'h02, 1'b0, 1'b0);
    tick();
    chk("stall_full_in_ready", 64'(in_ready), 64'd0);
    chk("stall_hold_dest", 64'(out_dest), 64'd7);
    drive(1'b0, 5'd0, 5'h00, 1'b0, 1'b0);
    tick();
    chk("stall_still_7", 64'(out_dest), 64'd7);
    chk("stall_still_full", 64'(in_ready), 64'd0);
    drive(1'b0, 5'd0, 5'h00, 1'b1, 1'b0);
    tick();
    chk("drain_8_dest", 64'(out_dest), 64'd8);
    chk("drain_8_ctrl", 64'(out_ctrl), 64'h02);
    chk("drain_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Flush while holding 7 and 8, with 9 offered
    drive(1'b1, 5'd7, 5'h01, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd8, 5'h02, 1'b0, 1'b0);
    tick();
    chk("pre_flush_full", 64'(in_ready), 64'd0);
    drive(1'b1, 5'd9, 5'h1F, 1'b0, 1'b1);
    tick();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
`else
    // Single register: in_ready follows out_ready combinationally while full
    drive(1'b1, 5'd7, 5'h03, 1'b0, 1'b0);
    tick();
    chk("nskid_valid", 64'(out_valid), 64'd1);
    chk("nskid_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("nskid_in_ready_comb", 64'(in_ready), 64'd1);
    drive(1'b1, 5'd9, 5'h1F, 1'b0, 1'b1);
    tick();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_ctrl", 64'(out_ctrl), 64'd0);
`endif
    drive(1'b0, 5'd0, 5'h00, 1'b1, 1'b0);
    tick();
    chk("flush_9_dropped", 64'(out_valid), 64'd0);

    // Bubble gating with control bits live on the input
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd9, 5'h1F, 1'($urandom_range(0, 1)), 1'b0);
      tick();
      chk("bubble_gate", 64'(out_ctrl), 64'd0);
    end

    // Randomized traffic, occasional flush and one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      in_data = $urandom;
      if (i == 1500) rst = 1'b0;
      if (i == 1503) rst = 1'b1;
      tick();
    end

    drive(1'b0, 5'd0, 5'h00, 1'b1, 1'b0);
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
